// File: rtl/qrs_pkg.sv
// Shared types, widths and helpers for the QRS peak detector.
// Holds the FSM state encoding and the saturating magnitude function.
package qrs_pkg;

    localparam int SAMPLE_W = 32;
    localparam int RR_W     = 16;

    typedef enum logic [1:0] {
        LEARN      = 2'd0,
        SEARCH     = 2'd1,
        PEAK       = 2'd2,
        REFRACTORY = 2'd3
    } qrs_state_t;

    // |x| as unsigned; the most negative input has no positive twin, so it clips to max.
    function automatic logic [SAMPLE_W-1:0] sat_abs(input logic signed [SAMPLE_W-1:0] x);
        logic [SAMPLE_W-1:0] u;
        u = x;
        if (u == {1'b1, {(SAMPLE_W-1){1'b0}}})
            return {1'b0, {(SAMPLE_W-1){1'b1}}};
        else if (x[SAMPLE_W-1])
            return ~u + SAMPLE_W'(1);
        else
            return u;
    endfunction

endpackage

// File: rtl/qrs_peak_detector_adaptive_threshold.sv
// Running signal-peak estimate (spk) and the detection threshold derived from it.
// Supports seeding from the learn phase, per-beat update and timeout halving.
module adaptive_threshold
    import qrs_pkg::*;
#(
    parameter logic [SAMPLE_W-1:0] INIT_THRESHOLD = 1000,
    parameter logic [SAMPLE_W-1:0] THRESH_MIN     = 100
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                learn_load,
    input  logic [SAMPLE_W-1:0] learn_max,
    input  logic                update,
    input  logic [SAMPLE_W-1:0] peak,
    input  logic                halve,
    output logic [SAMPLE_W-1:0] threshold
);

    logic [SAMPLE_W-1:0] spk;
    logic [SAMPLE_W-1:0] spk_next;

    function automatic logic [SAMPLE_W-1:0] clamp_min(input logic [SAMPLE_W-1:0] v);
        return (v < THRESH_MIN) ? THRESH_MIN : v;
    endfunction

    // spk tracks 7/8 of its old value plus 1/8 of the new beat's peak.
    assign spk_next = spk - (spk >> 3) + (peak >> 3);

    always_ff @(posedge clk) begin
        if (reset) begin
            spk       <= '0;
            threshold <= INIT_THRESHOLD;
        end else if (learn_load) begin
            spk       <= learn_max;
            threshold <= clamp_min(learn_max >> 1);
        end else if (update) begin
            spk       <= spk_next;
            threshold <= clamp_min(spk_next >> 1);
        end else if (halve) begin
            threshold <= clamp_min(threshold >> 1);
        end
    end

endmodule

// File: rtl/qrs_peak_detector.sv
// QRS peak detector: magnitude stage followed by a learn/search/peak/refractory FSM
// with an adaptive threshold; emits a one-clock pulse with peak amplitude and RR interval.
module qrs_peak_detector
    import qrs_pkg::*;
#(
    parameter int LEARN_SAMPLES      = 256,
    parameter int REFRACTORY_SAMPLES = 50,
    parameter int RR_MAX             = 500,
    parameter int INIT_THRESHOLD     = 1000,
    parameter int THRESH_MIN         = 100
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic signed [SAMPLE_W-1:0] filtered_ecg,
    output logic                       qrs_detected,
    output logic [SAMPLE_W-1:0]        peak_value,
    output logic [RR_W-1:0]            rr_interval,
    output logic [SAMPLE_W-1:0]        threshold,
    output logic [1:0]                 state_dbg
);

    logic [SAMPLE_W-1:0] mag_p1;
    logic                vld_p1;

    qrs_state_t          state;
    logic [RR_W-1:0]     cnt;
    logic [RR_W-1:0]     since;
    logic [SAMPLE_W-1:0] pk;
    logic [SAMPLE_W-1:0] lmax;
    logic [SAMPLE_W-1:0] lmax_next;
    logic                first_beat;
    logic                learn_done;
    logic                rise;
    logic                timeout;
    logic                trig;

    // ---- stage p1: sample magnitude ----
    always_ff @(posedge clk) begin
        if (enable)
            mag_p1 <= sat_abs(filtered_ecg);
    end

    always_ff @(posedge clk) begin
        if (reset)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= enable;
    end

    // ---- stage p2: detection FSM ----
    always_comb begin
        lmax_next  = (mag_p1 > lmax) ? mag_p1 : lmax;
        learn_done = vld_p1 && (state == LEARN) && (cnt == RR_W'(LEARN_SAMPLES - 1));
        rise       = vld_p1 && (state == SEARCH) && (mag_p1 > threshold);
        timeout    = vld_p1 && (state == SEARCH) && !rise && (cnt == RR_W'(RR_MAX - 1));
        trig       = vld_p1 && (state == PEAK) && (mag_p1 < (pk >> 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= LEARN;
            cnt          <= '0;
            since        <= '0;
            pk           <= '0;
            lmax         <= '0;
            first_beat   <= 1'b1;
            qrs_detected <= 1'b0;
            peak_value   <= '0;
            rr_interval  <= '0;
        end else begin
            qrs_detected <= 1'b0;
            if (vld_p1) begin
                since <= (since == '1) ? since : since + RR_W'(1);
                unique case (state)
                    LEARN: begin
                        lmax <= lmax_next;
                        if (learn_done) begin
                            state <= SEARCH;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + RR_W'(1);
                        end
                    end
                    SEARCH: begin
                        if (rise) begin
                            pk    <= mag_p1;
                            state <= PEAK;
                            cnt   <= '0;
                        end else if (timeout) begin
                            cnt <= '0;
                        end else begin
                            cnt <= cnt + RR_W'(1);
                        end
                    end
                    PEAK: begin
                        if (mag_p1 > pk) begin
                            pk <= mag_p1;
                        end else if (trig) begin
                            qrs_detected <= 1'b1;
                            peak_value   <= pk;
                            rr_interval  <= first_beat ? '0 :
                                            ((since == '1) ? since : since + RR_W'(1));
                            first_beat   <= 1'b0;
                            since        <= '0;
                            state        <= REFRACTORY;
                            cnt          <= '0;
                        end
                    end
                    REFRACTORY: begin
                        if (cnt == RR_W'(REFRACTORY_SAMPLES - 1)) begin
                            state <= SEARCH;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + RR_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign state_dbg = state;

    adaptive_threshold #(
        .INIT_THRESHOLD(SAMPLE_W'(INIT_THRESHOLD)),
        .THRESH_MIN    (SAMPLE_W'(THRESH_MIN))
    ) u_thresh (
        .clk       (clk),
        .reset     (reset),
        .learn_load(learn_done),
        .learn_max (lmax_next),
        .update    (trig),
        .peak      (pk),
        .halve     (timeout),
        .threshold (threshold)
    );

endmodule

// File: doc/qrs_peak_detector.md
Name: qrs_peak_detector

Overview:
- Downstream stage of the FIR low-pass filter; consumes the 32-bit signed `filtered_ecg` sample stream.
- Detects QRS peaks using an amplitude threshold that adapts to the signal, plus a refractory window.
- Outputs a one-clock detection pulse, the peak amplitude and the RR interval in samples, for the heart-rate and back-end logic.

Parameters:
- LEARN_SAMPLES, 256: number of accepted samples used to seed the threshold after reset.
- REFRACTORY_SAMPLES, 50: number of accepted samples ignored after each detection.
- RR_MAX, 500: accepted samples in SEARCH without a beat before the threshold is halved.
- INIT_THRESHOLD, 1000: threshold value during and out of reset.
- THRESH_MIN, 100: lower clamp on the threshold.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- enable  in  1  sample-valid strobe; `filtered_ecg` is accepted on any rising edge where enable=1.
- filtered_ecg  in  32  signed sample from the low-pass filter.
- qrs_detected  out  1  one-clock pulse per detected beat.
- peak_value  out  32  unsigned peak magnitude of the last beat.
- rr_interval  out  16  accepted samples between the last two beats; 0 on the first beat.
- threshold  out  32  current detection threshold.
- state_dbg  out  2  current FSM state encoding.

Behaviour:
- Clocking and reset:
  - Single clock; reset is synchronous and active-high.
  - On reset: qrs_detected=0, peak_value=0, rr_interval=0, threshold=INIT_THRESHOLD, spk=0, all counters=0, first_beat=1, state=LEARN.
  - Reset asserted mid-operation aborts any in-progress peak with no pulse.
- Magnitude stage:
  - On each accepted sample, register mag = |filtered_ecg| as 32-bit unsigned.
  - -2^31 saturates to 2^31-1.
  - mag_v pulses one cycle later.
- FSM advances only on mag_v. With enable=0 all state, counters and outputs hold, except that qrs_detected is forced to 0.
- Sample counter `since`:
  - Increments on every mag_v.
  - Saturates at 16'hFFFF.
  - Resets to 0 on the detection-trigger sample.
- LEARN:
  - Track the maximum mag over LEARN_SAMPLES samples.
  - On the last sample: spk=max, threshold=max(max>>1, THRESH_MIN), go to SEARCH.
  - No detections are made in LEARN.
- SEARCH:
  - mag > threshold (strict): peak=mag, go to PEAK.
  - Otherwise, when the search counter reaches RR_MAX: threshold=max(threshold>>1, THRESH_MIN), restart the search counter, stay in SEARCH.
- PEAK:
  - mag > peak: peak=mag.
  - Else if mag < peak>>1 (strict): trigger. The trigger does the following:
    - qrs_detected=1 on the same edge that registers the FSM update, i.e. 2 clocks after the trigger sample is accepted.
    - peak_value=peak.
    - rr_interval = since+1, or 0 if first_beat; first_beat is then cleared.
    - spk = spk - (spk>>3) + (peak>>3).
    - threshold = max(new spk>>1, THRESH_MIN).
    - Go to REFRACTORY.
  - Otherwise remain in PEAK.
- REFRACTORY:
  - Ignore amplitude for REFRACTORY_SAMPLES accepted samples.
  - Then go to SEARCH with the search counter cleared.
- Widths: spk is held in 32-bit unsigned.
- Pulse rules: qrs_detected is never high on two consecutive clocks; peak_value and rr_interval hold until the next trigger.

Decomposition:
- Package `qrs_pkg`:
  - FSM state enum: LEARN=0, SEARCH=1, PEAK=2, REFRACTORY=3.
  - Width constants: SAMPLE_W=32, RR_W=16.
  - Saturating-abs function.
- Optional sub-module `adaptive_threshold`:
  - Holds spk/threshold.
  - Implements the update, halve and clamp operations.
- FSM and counters live in the top module.

Test Plan:
Benches use LEARN_SAMPLES=8, REFRACTORY_SAMPLES=4, RR_MAX=64, INIT_THRESHOLD=1000, THRESH_MIN=100.
1. Reset: hold reset 2 clocks -> threshold=1000, all other outputs 0, state=LEARN; inputs while in reset are ignored.
2. Learn: 8 samples of -400 -> threshold=200, spk=400, state=SEARCH, no pulse.
3. First beat: samples 0,3000,5000,2000 -> one-clock qrs_detected 2 clocks after the 2000 sample; peak_value=5000, rr_interval=0, threshold=487.
4. Refractory: 6000 on the sample immediately after the trigger -> no pulse; after 4 samples, state=SEARCH.
5. RR: second beat triggers 20 accepted samples after the first (enable gapped 1-in-3) -> rr_interval=20; only samples with enable=1 are counted.
6. Timeout/boundaries:
   - 64 zero samples in SEARCH -> threshold 487 -> 243; repeated timeouts floor at 100.
   - Input -2^31 -> mag=2147483647.
   - Reset asserted in PEAK -> no pulse, LEARN.
